// File: rtl/dcache_responder_if.sv
// Datapath-side and memory-side bus of the data cache responder.
interface dcache_responder_if;
  logic        halt;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  modport slave (
    input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped write-back data cache responder, two-word blocks, flush on halt.
// Defining DCACHE_HITCNT_EN adds a first-cycle hit counter stored to HITCNT_ADDR after flush.
module dcache_responder #(
  parameter int unsigned NUM_SETS    = 16,
  parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100
) (
  input logic               CLK,
  input logic               nRST,
  dcache_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 29 - IDX_W;

  typedef enum logic [3:0] {
    StIdle, StWb0, StWb1, StLd0, StLd1, StFlush, StFwb0, StFwb1, StCnt, StDone
  } state_t;

  state_t              state_q;
  logic [NUM_SETS-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]    tag_q   [NUM_SETS];
  logic [31:0]         word0_q [NUM_SETS];
  logic [31:0]         word1_q [NUM_SETS];
  logic [TAG_W-1:0]    miss_tag_q;
  logic [IDX_W-1:0]    miss_idx_q, fidx_q;
  logic                dren_q, dwen_q, flushed_q;
  logic [31:0]         daddr_q, dstore_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             req_blk, req, hit, flush_last;

  assign req_tag    = bus.dmemaddr[31:3+IDX_W];
  assign req_idx    = bus.dmemaddr[2+IDX_W:3];
  assign req_blk    = bus.dmemaddr[2];
  assign req        = bus.dmemREN | bus.dmemWEN;
  assign hit        = (state_q == StIdle) && req && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign flush_last = (fidx_q == IDX_W'(NUM_SETS - 1));

  assign bus.dhit     = hit;
  assign bus.dmemload = (hit && !bus.dmemWEN) ? (req_blk ? word1_q[req_idx] : word0_q[req_idx]) : '0;
  assign bus.flushed  = flushed_q;
  assign bus.dREN     = dren_q;
  assign bus.dWEN     = dwen_q;
  assign bus.daddr    = daddr_q;
  assign bus.dstore   = dstore_q;

  // Register values loaded when the flush walk finishes its last set.
  state_t      term_state;
  logic        term_dwen;
  logic [31:0] term_daddr, term_dstore;

`ifdef DCACHE_HITCNT_EN
  logic [31:0] hitcnt_q;
  logic        refill_q;

  // refill_q marks the IDLE cycle right after a refill, whose hit is not counted.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      hitcnt_q <= '0;
      refill_q <= 1'b0;
    end else begin
      refill_q <= (state_q == StLd1) && !bus.dwait;
      if (hit && !refill_q) hitcnt_q <= hitcnt_q + 32'd1;
    end
  end

  assign term_state  = StCnt;
  assign term_dwen   = 1'b1;
  assign term_daddr  = HITCNT_ADDR;
  assign term_dstore = hitcnt_q;

  logic unused_bits;
  assign unused_bits = ^bus.dmemaddr[1:0];
`else
  assign term_state  = StDone;
  assign term_dwen   = 1'b0;
  assign term_daddr  = '0;
  assign term_dstore = '0;

  logic unused_bits;
  assign unused_bits = ^{bus.dmemaddr[1:0], HITCNT_ADDR};
`endif

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      dirty_q    <= '0;
      fidx_q     <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      dren_q     <= 1'b0;
      dwen_q     <= 1'b0;
      flushed_q  <= 1'b0;
      daddr_q    <= '0;
      dstore_q   <= '0;
      for (int i = 0; i < NUM_SETS; i++) begin
        tag_q[i]   <= '0;
        word0_q[i] <= '0;
        word1_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (hit) begin
              if (bus.dmemWEN) begin
                if (req_blk) word1_q[req_idx] <= bus.dmemstore;
                else         word0_q[req_idx] <= bus.dmemstore;
                dirty_q[req_idx] <= 1'b1;
              end
            end else begin
              miss_tag_q <= req_tag;
              miss_idx_q <= req_idx;
              if (dirty_q[req_idx]) begin
                state_q  <= StWb0;
                dwen_q   <= 1'b1;
                daddr_q  <= {tag_q[req_idx], req_idx, 3'b000};
                dstore_q <= word0_q[req_idx];
              end else begin
                state_q <= StLd0;
                dren_q  <= 1'b1;
                daddr_q <= {req_tag, req_idx, 3'b000};
              end
            end
          end else if (bus.halt) begin
            state_q <= StFlush;
          end
        end
        StWb0: if (!bus.dwait) begin
          state_q  <= StWb1;
          daddr_q  <= {tag_q[miss_idx_q], miss_idx_q, 3'b100};
          dstore_q <= word1_q[miss_idx_q];
        end
        StWb1: if (!bus.dwait) begin
          state_q  <= StLd0;
          dwen_q   <= 1'b0;
          dren_q   <= 1'b1;
          daddr_q  <= {miss_tag_q, miss_idx_q, 3'b000};
          dstore_q <= '0;
        end
        StLd0: if (!bus.dwait) begin
          state_q             <= StLd1;
          word0_q[miss_idx_q] <= bus.dload;
          daddr_q             <= {miss_tag_q, miss_idx_q, 3'b100};
        end
        StLd1: if (!bus.dwait) begin
          state_q             <= StIdle;
          word1_q[miss_idx_q] <= bus.dload;
          valid_q[miss_idx_q] <= 1'b1;
          dirty_q[miss_idx_q] <= 1'b0;
          tag_q[miss_idx_q]   <= miss_tag_q;
          dren_q              <= 1'b0;
          daddr_q             <= '0;
        end
        StFlush: begin
          if (dirty_q[fidx_q]) begin
            state_q  <= StFwb0;
            dwen_q   <= 1'b1;
            daddr_q  <= {tag_q[fidx_q], fidx_q, 3'b000};
            dstore_q <= word0_q[fidx_q];
          end else begin
            fidx_q <= fidx_q + IDX_W'(1);
            if (flush_last) begin
              state_q   <= term_state;
              dwen_q    <= term_dwen;
              daddr_q   <= term_daddr;
              dstore_q  <= term_dstore;
              flushed_q <= (term_state == StDone);
            end
          end
        end
        StFwb0: if (!bus.dwait) begin
          state_q  <= StFwb1;
          daddr_q  <= {tag_q[fidx_q], fidx_q, 3'b100};
          dstore_q <= word1_q[fidx_q];
        end
        StFwb1: if (!bus.dwait) begin
          dirty_q[fidx_q] <= 1'b0;
          fidx_q          <= fidx_q + IDX_W'(1);
          if (flush_last) begin
            state_q   <= term_state;
            dwen_q    <= term_dwen;
            daddr_q   <= term_daddr;
            dstore_q  <= term_dstore;
            flushed_q <= (term_state == StDone);
          end else begin
            state_q  <= StFlush;
            dwen_q   <= 1'b0;
            daddr_q  <= '0;
            dstore_q <= '0;
          end
        end
        StCnt: if (!bus.dwait) begin
          state_q   <= StDone;
          dwen_q    <= 1'b0;
          daddr_q   <= '0;
          dstore_q  <= '0;
          flushed_q <= 1'b1;
        end
        StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: a set-level cache model predicts memory transfers,
// hits and read data; one negedge process checks every cycle and plays the memory.
module tb_dcache_responder;
  logic CLK;
  logic nRST;
  dcache_responder_if bus ();

  dcache_responder dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Memory and cache model
  logic [31:0] mem [logic [31:0]];
  logic        m_valid [16];
  logic        m_dirty [16];
  logic [24:0] m_tag   [16];
  logic [31:0] m_data  [16][2];
  int          m_hits = 0;
  logic        m_done = 1'b0;
  logic        m_flushing = 1'b0;

  // Expected transfers, and log of completed ones
  logic        eq_w [$];
  logic [31:0] eq_a [$];
  logic [31:0] eq_d [$];
  logic        log_w [$];
  logic [31:0] log_a [$];
  logic [31:0] log_d [$];

  logic        req_on = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] exp_load = '0;
  logic        exp_hit;
  logic        last_dhit = 1'b0;
  logic [31:0] last_load = '0;
  int          wait_cycles = 0;
  int          wait_left = 0;
  int          gap = 0;
  int          lat;
  int          cnt;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    eq_w.push_back(w);
    eq_a.push_back(a);
    eq_d.push_back(d);
  endtask

  task automatic clear_queues();
    eq_w.delete(); eq_a.delete(); eq_d.delete();
    log_w.delete(); log_a.delete(); log_d.delete();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_done = 1'b0;
    m_flushing = 1'b0;
  endtask

  task automatic chk_rst_outputs(input string pfx);
    chk1({pfx, "_dhit"}, bus.dhit, 1'b0);
    chk({pfx, "_dmemload"}, bus.dmemload, 32'h0);
    chk1({pfx, "_flushed"}, bus.flushed, 1'b0);
    chk1({pfx, "_dREN"}, bus.dREN, 1'b0);
    chk1({pfx, "_dWEN"}, bus.dWEN, 1'b0);
    chk({pfx, "_daddr"}, bus.daddr, 32'h0);
    chk({pfx, "_dstore"}, bus.dstore, 32'h0);
  endtask

  // Every cycle: check outputs against the model and act as the memory.
  always @(negedge CLK) begin
    if (nRST) begin
      exp_hit = req_on && (eq_a.size() == 0) && !m_done;
      chk1("dhit", bus.dhit, exp_hit);
      last_dhit = bus.dhit;
      last_load = bus.dmemload;
      if (bus.dhit && !req_we) chk("dmemload", bus.dmemload, exp_load);
      chk1("ren_wen_excl", bus.dREN & bus.dWEN, 1'b0);
      if (m_done) chk1("flushed_held", bus.flushed, 1'b1);
      else if (!m_flushing) chk1("flushed_early", bus.flushed, 1'b0);
      if (bus.dREN || bus.dWEN) begin
        gap = 0;
        if (eq_a.size() == 0) begin
          chk1("spurious_xfer", bus.dREN | bus.dWEN, 1'b0);
          bus.dwait = 1'b1;
        end else begin
          chk1("xfer_dir", bus.dWEN, eq_w[0]);
          chk("xfer_addr", bus.daddr, eq_a[0]);
          if (eq_w[0]) chk("xfer_data", bus.dstore, eq_d[0]);
          if (wait_left > 0) begin
            bus.dwait = 1'b1;
            bus.dload = 32'hBAD0_BAD0;
            wait_left--;
          end else begin
            bus.dwait = 1'b0;
            if (bus.dWEN) mem[bus.daddr] = bus.dstore;
            else          bus.dload = mem_rd(bus.daddr);
            log_w.push_back(bus.dWEN);
            log_a.push_back(bus.daddr);
            log_d.push_back(bus.dWEN ? bus.dstore : mem_rd(bus.daddr));
            void'(eq_w.pop_front());
            void'(eq_a.pop_front());
            void'(eq_d.pop_front());
            wait_left = wait_cycles;
          end
        end
      end else begin
        bus.dwait = 1'b1;
        if (eq_a.size() != 0) begin
          gap++;
          if (gap == 40) begin
            total++;
            bad++;
            $display("FAIL xfer_timeout: got no transfer in 40 cycles, want %h", eq_a[0]);
          end
        end
      end
    end
  end

  // One datapath request: predict transfers from the model, then drive until dhit.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lt);
    int          idx;
    logic [24:0] tag;
    int          blk;
    idx = int'(addr[6:3]);
    tag = addr[31:7];
    blk = int'(addr[2]);
    log_w.delete(); log_a.delete(); log_d.delete();
    if (m_valid[idx] && m_tag[idx] == tag) begin
      m_hits++;
    end else begin
      if (m_dirty[idx]) begin
        push(1'b1, {m_tag[idx], addr[6:3], 3'b000}, m_data[idx][0]);
        push(1'b1, {m_tag[idx], addr[6:3], 3'b100}, m_data[idx][1]);
      end
      push(1'b0, {addr[31:3], 3'b000}, 32'h0);
      push(1'b0, {addr[31:3], 3'b100}, 32'h0);
      m_data[idx][0] = mem_rd({addr[31:3], 3'b000});
      m_data[idx][1] = mem_rd({addr[31:3], 3'b100});
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx] = tag;
    end
    if (we) begin
      m_data[idx][blk] = wdata;
      m_dirty[idx] = 1'b1;
    end
    exp_load = m_data[idx][blk];
    req_we = we;
    bus.dmemREN = !we;
    bus.dmemWEN = we;
    bus.dmemaddr = addr;
    bus.dmemstore = wdata;
    req_on = 1'b1;
    lt = 0;
    do begin
      @(negedge CLK);
      #1;
      lt++;
    end while (!last_dhit && lt < 200);
    @(posedge CLK);
    #1;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    req_on = 1'b0;
  endtask

  initial begin
    nRST = 1'b1;
    bus.halt = 1'b0;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    bus.dmemaddr = '0;
    bus.dmemstore = '0;
    bus.dwait = 1'b1;
    bus.dload = '0;
    model_reset();
    mem[32'h40]  = 32'h11;
    mem[32'h44]  = 32'h22;
    mem[32'h840] = 32'h33;
    mem[32'h844] = 32'h44;
    mem[32'h48]  = 32'h99;
    mem[32'h4C]  = 32'hAA;
    #1 nRST = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk_rst_outputs("reset");
    @(posedge CLK);
    #1 nRST = 1'b1;

    // Cold read: LD 0x40, LD 0x44, then hit
    access(1'b0, 32'h40, 32'h0, lat);
    chk("cold_lat", 32'(lat), 32'd4);
    chk("cold_load", last_load, 32'h11);
    chk("cold_xfers", 32'(log_a.size()), 32'd2);
    chk("cold_addr0", log_a[0], 32'h40);
    chk("cold_addr1", log_a[1], 32'h44);

    access(1'b0, 32'h44, 32'h0, lat);
    chk("hit_lat", 32'(lat), 32'd1);
    chk("hit_load", last_load, 32'h22);

    access(1'b1, 32'h40, 32'hDEAD_BEEF, lat);
    chk("whit_lat", 32'(lat), 32'd1);
    access(1'b0, 32'h40, 32'h0, lat);
    chk("whit_load", last_load, 32'hDEAD_BEEF);

    // Dirty conflict on set 8
    access(1'b0, 32'h840, 32'h0, lat);
    chk("dirty_lat", 32'(lat), 32'd6);
    chk("dirty_load", last_load, 32'h33);
    chk1("dirty_w0", log_w[0], 1'b1);
    chk("dirty_a0", log_a[0], 32'h40);
    chk("dirty_d0", log_d[0], 32'hDEAD_BEEF);
    chk("dirty_a1", log_a[1], 32'h44);
    chk("dirty_d1", log_d[1], 32'h22);
    chk1("dirty_w2", log_w[2], 1'b0);
    chk("dirty_a2", log_a[2], 32'h840);
    chk("dirty_a3", log_a[3], 32'h844);

    // Slow memory: 5 wait cycles on every transfer of a dirty miss
    access(1'b1, 32'h844, 32'h55, lat);
    wait_cycles = 5;
    wait_left = 5;
    access(1'b0, 32'h40, 32'h0, lat);
    chk("slow_lat", 32'(lat), 32'd26);
    chk("slow_load", last_load, 32'hDEAD_BEEF);
    chk("slow_d1", log_d[1], 32'h55);
    wait_cycles = 0;
    wait_left = 0;

    // Dirty sets 2 and 7, then flush
    access(1'b1, 32'h10, 32'hA5A5_0002, lat);
    access(1'b1, 32'h3C, 32'h7777_0007, lat);
    m_flushing = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (m_dirty[i]) begin
        push(1'b1, {m_tag[i], 4'(i), 3'b000}, m_data[i][0]);
        push(1'b1, {m_tag[i], 4'(i), 3'b100}, m_data[i][1]);
        m_dirty[i] = 1'b0;
      end
    end
`ifdef DCACHE_HITCNT_EN
    push(1'b1, 32'h3100, 32'(m_hits));
`endif
    log_w.delete(); log_a.delete(); log_d.delete();
    bus.halt = 1'b1;
    cnt = 0;
    do begin
      @(negedge CLK);
      #1;
      cnt++;
    end while (!bus.flushed && cnt < 300);
    chk1("flushed_seen", bus.flushed, 1'b1);
    m_done = 1'b1;
    bus.halt = 1'b0;
`ifdef DCACHE_HITCNT_EN
    chk("flush_xfers", 32'(log_a.size()), 32'd5);
    chk("hitcnt_addr", log_a[4], 32'h3100);
    chk("hitcnt_val", log_d[4], 32'd4);
`else
    chk("flush_xfers", 32'(log_a.size()), 32'd4);
`endif
    chk("flush_a0", log_a[0], 32'h10);
    chk("flush_d0", log_d[0], 32'hA5A5_0002);
    chk("flush_a1", log_a[1], 32'h14);
    chk("flush_a2", log_a[2], 32'h38);
    chk("flush_a3", log_a[3], 32'h3C);
    chk("flush_d3", log_d[3], 32'h7777_0007);

    // Requests after flush are ignored; flushed stays high
    bus.dmemaddr = 32'h44;
    bus.dmemREN = 1'b1;
    req_we = 1'b0;
    req_on = 1'b1;
    repeat (4) @(negedge CLK);
    @(posedge CLK);
    #1;
    bus.dmemREN = 1'b0;
    req_on = 1'b0;

    nRST = 1'b0;
    model_reset();
    clear_queues();
    @(posedge CLK);
    #1 nRST = 1'b1;

    // Reset during LD1 of a refill
    wait_cycles = 3;
    wait_left = 3;
    push(1'b0, 32'h48, 32'h0);
    push(1'b0, 32'h4C, 32'h0);
    bus.dmemaddr = 32'h48;
    bus.dmemREN = 1'b1;
    req_we = 1'b0;
    req_on = 1'b1;
    cnt = 0;
    do begin
      @(negedge CLK);
      #1;
      cnt++;
    end while (!(bus.dREN && bus.daddr == 32'h4C) && cnt < 100);
    chk("reached_ld1", bus.daddr, 32'h4C);
    nRST = 1'b0;
    req_on = 1'b0;
    bus.dmemREN = 1'b0;
    clear_queues();
    model_reset();
    #1;
    chk_rst_outputs("rst_mid");
    wait_cycles = 0;
    wait_left = 0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    access(1'b0, 32'h48, 32'h0, lat);
    chk("rearm_lat", 32'(lat), 32'd4);
    chk("rearm_xfers", 32'(log_a.size()), 32'd2);
    chk("rearm_load", last_load, 32'h99);

    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Data-side responder of the datapath/cache interface. Services the pipeline's dmemREN/dmemWEN requests and returns dhit/dmemload.
- Direct-mapped, write-back, write-allocate cache with two-word blocks. Refills and write-backs go over a single-word memory request port (dREN/dWEN/dwait).
- On datapath halt, writes back all dirty lines, then asserts flushed.

Parameters:
- NUM_SETS, 16: number of sets; power of 2; IDX_W = log2(NUM_SETS).
- HITCNT_ADDR, 32'h00003100: address for the hit-count store (optional feature only).

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset.
- halt  in  1  datapath halted; starts flush.
- dmemREN  in  1  datapath read request.
- dmemWEN  in  1  datapath write request.
- dmemaddr  in  32  word address (bits [1:0] ignored).
- dmemstore  in  32  write data.
- dhit  out  1  request completed this cycle.
- dmemload  out  32  read data; valid when dhit.
- flushed  out  1  flush complete; held until reset.
- dREN  out  1  memory read request.
- dWEN  out  1  memory write request.
- daddr  out  32  memory word address.
- dstore  out  32  memory write data.
- dwait  in  1  memory busy; the transfer completes in a cycle with dwait=0.
- dload  in  32  memory read data; valid when dwait=0.

Interface decision: reset nRST, asynchronous, active-low; clock CLK.

Behaviour:
- Address split: tag = [31:3+IDX_W], idx = [2+IDX_W:3], blk = [2]. Default tag width is 25.
- Per set: valid, dirty, tag, word0, word1.
- Reset: all valid and dirty bits = 0; FSM = IDLE; hit counter = 0; flush index = 0.
- Reset output values: dhit=0, dmemload=0, flushed=0, dREN=0, dWEN=0, daddr=0, dstore=0.
- Reset mid-operation aborts any transfer immediately; no partial state is retained.
- States: IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, CNT, DONE.
- IDLE:
  - Hit = request && valid && tag match. dhit is combinational, same cycle.
  - Read hit: dmemload = word[blk].
  - Write hit: word[blk] <= dmemstore at the clock edge; dirty <= 1.
  - If dmemREN and dmemWEN are both high, treat as a write.
  - Miss with dirty line -> WB0. Miss with clean line -> LD0. dhit=0 during any miss.
- WB0 / WB1:
  - dWEN=1; daddr = {stored tag, idx, blk, 2'b00} with blk = 0 / 1; dstore = word0 / word1.
  - Advance on dwait=0: WB0 -> WB1 -> LD0.
- LD0 / LD1:
  - dREN=1; daddr = {request tag, idx, blk, 2'b00} with blk = 0 / 1.
  - On dwait=0, latch dload into word0 / word1.
  - On leaving LD1: valid=1, tag updated, dirty=0, -> IDLE. The request then hits on the next cycle.
  - Minimum miss latency: 2 memory transfers clean, 4 dirty, plus 1 hit cycle.
- Halt:
  - Sampled only in IDLE with no request pending. halt during miss service is deferred until return to IDLE.
  - IDLE+halt -> FLUSH.
- FLUSH:
  - Examine set[flush index]. Dirty -> FWB0.
  - Clean -> increment index; after set NUM_SETS-1 -> CNT if feature enabled, else DONE.
- FWB0 / FWB1: same as WB0 / WB1. On leaving FWB1: dirty=0, increment index, -> FLUSH or terminal state.
- DONE: flushed=1; all memory outputs 0; datapath requests ignored (dhit=0). Only reset exits DONE.
- Only one of dREN/dWEN is ever high; both are low in IDLE and DONE.

Optional Feature:
- Macro DCACHE_HITCNT_EN.
- Defined:
  - A 32-bit counter increments on each dhit whose request hit on its first IDLE cycle. The hit following a refill is not counted.
  - State CNT issues dWEN with daddr=HITCNT_ADDR and dstore=count, holding until dwait=0, then -> DONE.
- Undefined: no counter, no CNT state; the flush goes straight to DONE.

Test Plan:
- Cold read of 0x00000040 with memory words 0x11/0x22:
  - dREN at 0x40, then at 0x44; dhit on the following cycle with dmemload=0x11.
  - A subsequent read of 0x44 hits the same cycle with dmemload 0x22.
- Write hit:
  - After the fill above, write 0xDEADBEEF to 0x40 -> same-cycle dhit; no dREN/dWEN.
  - Read of 0x40 -> 0xDEADBEEF.
- Dirty conflict: with 0x40 dirty, read 0x00000840 (same idx, different tag):
  - dWEN 0x40=0xDEADBEEF, then dWEN 0x44=0x22, then dREN 0x840, 0x844, then dhit.
- dwait held high for 5 cycles in each phase:
  - Outputs stay stable; no state advance; dhit stays 0 throughout.
- Halt with sets 2 and 7 dirty:
  - Exactly 4 dWEN transfers in index order, then flushed=1 and held.
  - With DCACHE_HITCNT_EN: a 5th write to 0x3100 carrying the first-cycle hit count.
- Assert nRST during LD1:
  - All outputs 0; line not valid.
  - Re-issued read performs a full refill.
